load_store_unit: RTL and testbench

//  Multi-cycle data-memory access stage sitting directly downstream of the decode controller.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 54 +++++
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared state encoding, access-size and load-type constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_LOAD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access width of a load; undefined funct3 values behave as LW.
    function automatic logic [1:0] ld_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobes/replicated data, load extract and extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] st_lanes,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [1:0]  ld_eff_off;
    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        st_strb  = 4'b0000;
        st_lanes = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_strb  = 4'b0001 << st_off;
                st_lanes = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_strb  = 4'b0011 << {st_off[1], 1'b0};
                st_lanes = {2{st_data[15:0]}};
            end
            SZ_WORD: st_strb = 4'b1111;
            default: ;
        endcase
    end

    // Offset bits finer than the access size are ignored, matching the store side.
    always_comb begin
        case (ld_size(ld_funct3))
            SZ_BYTE: ld_eff_off = ld_off;
            SZ_HALF: ld_eff_off = {ld_off[1], 1'b0};
            default: ld_eff_off = 2'b00;
        endcase
        shifted = rdata >> {ld_eff_off, 3'b000};
        case (ld_funct3)
            F3_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  ld_data = {24'b0, shifted[7:0]};
            F3_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  ld_data = {16'b0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage: req/gnt/rvalid bus FSM, core stall and load return.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of ignoring low bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              memory_en,
    input  logic [1:0]        store_size,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              bus_err,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned    CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_load_q, is_load_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_wstrb_q, mem_wstrb_d;
    logic [31:0]         load_data_q, load_data_d;
    logic                bus_err_q, bus_err_d;
`ifdef MISALIGN_TRAP_EN
    logic                misalign_q, misalign_d;
    logic [1:0]          acc_size;
`endif

    logic [3:0]  st_strb;
    logic [31:0] st_lanes;
    logic [31:0] ld_data;
    logic        timeout_hit;

    lsu_align u_align (
        .st_size   (store_size),
        .st_off    (addr[1:0]),
        .st_data   (wdata),
        .st_strb   (st_strb),
        .st_lanes  (st_lanes),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .rdata     (mem_rdata),
        .ld_data   (ld_data)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
`ifdef MISALIGN_TRAP_EN
    assign acc_size = (store_size == SZ_LOAD) ? ld_size(funct3) : store_size;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        load_data_d = load_data_q;
        bus_err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (memory_en) begin
                    is_load_d   = (store_size == SZ_LOAD);
                    funct3_d    = funct3;
                    off_d       = addr[1:0];
                    mem_we_d    = (store_size != SZ_LOAD);
                    mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = st_lanes;
                    mem_wstrb_d = st_strb;
                    cnt_d       = '0;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned(acc_size, addr[1:0])) begin
                        state_d     = DONE;
                        misalign_d  = 1'b1;
                        load_data_d = '0;
                    end else
`endif
                    begin
                        state_d   = REQ;
                        mem_req_d = 1'b1;
                    end
                end
            end
            REQ: begin
                // rvalid is deliberately not looked at here, even alongside gnt.
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = is_load_q ? WAIT : DONE;
                end else if (timeout_hit) begin
                    mem_req_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                    state_d     = DONE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    load_data_d = ld_data;
                    state_d     = DONE;
                end else if (timeout_hit) begin
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_load_q   <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            load_data_q <= '0;
            bus_err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign stall     = memory_en && (state_q != DONE);
    assign load_data = load_data_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model plus literal pins.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TO = 8;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        memory_en;
    logic [1:0]  store_size;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .memory_en  (memory_en),
        .store_size (store_size),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_data  (load_data),
        .bus_err    (bus_err),
`ifdef MISALIGN_TRAP_EN
        .misalign   (misalign),
`endif
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model of what the bus and core should see.
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> (8 * (a % 4)));
        h = 16'(rd >> (16 * ((a / 2) % 2)));
        case (f3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LBU:  return {24'b0, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LHU:  return {16'b0, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            SZ_BYTE: return 4'(1 << (a % 4));
            SZ_HALF: return ((a / 2) % 2 == 1) ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        case (sz)
            SZ_BYTE: return {4{w[7:0]}};
            SZ_HALF: return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_err, chk_ld, chk_wd;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_strb;

    always @(negedge CLK) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("mem_req", 32'(mem_req), 32'(exp_req));
            check("bus_err", 32'(bus_err), 32'(exp_err));
            if (exp_req) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
                if (chk_wd) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (chk_ld) check("load_data", load_data, exp_ld);
        end
    end

    int          n_stall, n_req;
    logic [31:0] cap_addr, cap_wdata, cap_ld;
    logic [3:0]  cap_strb;
    logic        cap_err;

    // Starts at posedge+1 with the unit idle; g = REQ cycles before gnt, rv = WAIT cycles before rvalid.
    task automatic run_txn(input logic [1:0] sz, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] w, input logic [31:0] rd, input int g, input int rv,
                           input bit no_gnt, input bit rv_early);
        bit ld;
        int req_last, rv_c, done_c;
        ld       = (sz == SZ_LOAD);
        rv_c     = 2 + g + rv;
        req_last = no_gnt ? TO : 1 + g;
        done_c   = no_gnt ? TO + 1 : (ld ? rv_c + 1 : 2 + g);
        memory_en = 1'b1; store_size = sz; funct3 = f3; addr = a; wdata = w;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_we    = !ld;
        exp_strb  = m_strb(sz, a);
        exp_wdata = m_wdata(sz, w);
        chk_wd    = !ld;
        exp_ld    = no_gnt ? 32'h0 : m_load(f3, a, rd);
        n_stall = 0; n_req = 0;
        for (int c = 0; c <= done_c; c++) begin
            mem_gnt    = !no_gnt && (c == 1 + g);
            mem_rvalid = ld && !no_gnt && ((c == rv_c) || (rv_early && c == 1 + g));
            mem_rdata  = (c == rv_c) ? rd : 32'hA5A5_A5A5;
            exp_stall  = (c != done_c);
            exp_req    = (c >= 1) && (c <= req_last);
            exp_err    = no_gnt && (c == done_c);
            chk_ld     = (c == done_c) && (ld || no_gnt);
            chk_en     = 1'b1;
            @(negedge CLK);
            if (stall) n_stall++;
            if (mem_req) n_req++;
            if (c == 1) begin
                cap_addr = mem_addr; cap_wdata = mem_wdata; cap_strb = mem_wstrb;
            end
            if (c == done_c) begin
                cap_ld = load_data; cap_err = bus_err;
            end
            @(posedge CLK); #1;
        end
        memory_en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; chk_ld = 1'b0;
        @(negedge CLK);
        @(posedge CLK); #1;
        chk_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; memory_en = 1'b0; store_size = SZ_LOAD; funct3 = F3_LW;
        addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;

        run_txn(SZ_WORD, F3_LW, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 1'b0);
        check("sw_wdata_lit", cap_wdata, 32'hDEAD_BEEF);
        check("sw_strb_lit", 32'(cap_strb), 32'hF);
        check("sw_stall_cycles", n_stall, 2);

        run_txn(SZ_BYTE, F3_LW, 32'h103, 32'h0000_00AB, 32'h0, 0, 0, 1'b0, 1'b0);
        check("sb_addr_lit", cap_addr, 32'h100);
        check("sb_strb_lit", 32'(cap_strb), 32'h8);
        check("sb_wdata_lit", cap_wdata, 32'hABAB_ABAB);

        run_txn(SZ_HALF, F3_LW, 32'h102, 32'h0000_1234, 32'h0, 1, 0, 1'b0, 1'b0);
        check("sh_wdata_lit", cap_wdata, 32'h1234_1234);

        run_txn(SZ_LOAD, F3_LB, 32'h102, 32'h0, 32'h12F4_5678, 0, 0, 1'b0, 1'b0);
        check("lb_lit", cap_ld, 32'hFFFF_FFF4);
        run_txn(SZ_LOAD, F3_LBU, 32'h102, 32'h0, 32'h12F4_5678, 0, 0, 1'b0, 1'b0);
        check("lbu_lit", cap_ld, 32'h0000_00F4);
        run_txn(SZ_LOAD, F3_LH, 32'h102, 32'h0, 32'h8001_1234, 0, 1, 1'b0, 1'b1);
        check("lh_lit", cap_ld, 32'hFFFF_8001);
        run_txn(SZ_LOAD, F3_LHU, 32'h100, 32'h0, 32'h8001_F234, 1, 0, 1'b0, 1'b0);
        check("lhu_lit", cap_ld, 32'h0000_F234);
        run_txn(SZ_LOAD, F3_LW, 32'h104, 32'h0, 32'hCAFE_F00D, 3, 1, 1'b0, 1'b0);
        check("lw_req_cycles", n_req, 4);
        check("lw_lit", cap_ld, 32'hCAFE_F00D);
        run_txn(SZ_LOAD, 3'b111, 32'h108, 32'h0, 32'h0BAD_CAFE, 0, 0, 1'b0, 1'b0);

        // Reset while waiting for rvalid, then a late rvalid that must be ignored.
        memory_en = 1'b1; store_size = SZ_LOAD; funct3 = F3_LW; addr = 32'h200;
        @(posedge CLK); #1;
        mem_gnt = 1'b1;
        @(posedge CLK); #1;
        mem_gnt = 1'b0; RST_N = 1'b0;
        @(negedge CLK);
        check("wait_stall", 32'(stall), 32'h1);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst_wait_req", 32'(mem_req), 32'h0);
        check("rst_wait_stall_en", 32'(stall), 32'h1);
        check("rst_wait_load", load_data, 32'h0);
        memory_en = 1'b0;
        #1;
        check("rst_wait_stall_dis", 32'(stall), 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5566_7788;
        @(posedge CLK); #1;
        mem_rvalid = 1'b0;
        @(negedge CLK);
        check("late_rvalid_load", load_data, 32'h0);
        check("late_rvalid_req", 32'(mem_req), 32'h0);
        check("late_rvalid_err", 32'(bus_err), 32'h0);
        @(posedge CLK); #1;

        run_txn(SZ_LOAD, F3_LW, 32'h10C, 32'h0, 32'h1357_9BDF, 0, 0, 1'b0, 1'b0);
        run_txn(SZ_LOAD, F3_LW, 32'h110, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);
        check("to_err_lit", 32'(cap_err), 32'h1);
        check("to_load_lit", cap_ld, 32'h0);
        check("to_req_cycles", n_req, TO);

`ifdef MISALIGN_TRAP_EN
        memory_en = 1'b1; store_size = SZ_LOAD; funct3 = F3_LW; addr = 32'h101;
        @(negedge CLK);
        check("mis_req0", 32'(mem_req), 32'h0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("mis_pulse", 32'(misalign), 32'h1);
        check("mis_req1", 32'(mem_req), 32'h0);
        check("mis_stall", 32'(stall), 32'h0);
        check("mis_load", load_data, 32'h0);
        @(posedge CLK); #1;
        memory_en = 1'b0;
        @(negedge CLK);
        check("mis_clear", 32'(misalign), 32'h0);
        @(posedge CLK); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
